sevenseg_scan: RTL
==================

# sevenseg_scan

Time-multiplexed 4-digit seven-segment display driver that consumes the 12-bit packed BCD value produced by the binary-to-BCD converter. It latches a new value on a valid strobe and commits it only at a scan-frame boundary, so a displayed frame never mixes old and new digits. It then drives active-low anode and segment lines for the board display, one digit per refresh slot.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (100 MHz gives a 1 kHz digit rate and a 250 Hz frame rate); must be ≥ 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- bcd  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- bcd_valid  in  1  single-cycle strobe; `bcd` is sampled on the clk edge where this is high.
- an  out  4  anode enables, active-low; an[0] is the ones digit, an[3] is the leftmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; always 1 (off) outside reset.

## Operation
- **Pending register.** On every edge with bcd_valid=1, `pend <= bcd` and `pend_flag <= 1`. Back-to-back strobes overwrite `pend`, so the last one wins.
- **Refresh counter.** `cnt` counts 0..REFRESH_DIV-1 and wraps to 0. `tick` = (cnt == REFRESH_DIV-1).
- **Digit index.** `dig` is 2 bits. On each tick, `dig <= dig + 1` (mod 4).
- **Frame commit.** On the tick where `dig` wraps 3→0, `hold` is loaded from a commit source:
  - if bcd_valid=1 on that same edge, the commit source is `bcd`;
  - else if pend_flag=1, the commit source is `pend`;
  - otherwise `hold` is unchanged.
  - pend_flag is cleared on that edge.
  - Digit 0 of the new frame decodes from the committed value.
- **Digit decode.**
  - Slots 0–2 decode nibbles [3:0], [7:4] and [11:8] of `hold` respectively.
  - Slot 3 is always dark: an=1111 and seg=1111111.
  - A nibble > 9 (malformed BCD) displays "-": seg = 0111111, only g lit.
  - Standard patterns: 0 = 1000000, 1 = 1111001, 8 = 0000000.
- **Anode encoding.** an = ~(4'b0001 << dig) for slots 0–2.

## Timing
- `an`, `seg` and `dp` are registers. They are loaded on the tick edge with the values for the new `dig`.
- Reset state, asynchronous:
  - cnt = 0, dig = 3;
  - hold = 000, pend = 000, pend_flag = 0;
  - an = 1111, seg = 1111111, dp = 1.
- The first tick after reset is at cycle REFRESH_DIV. It wraps dig 3→0, commits any pending value, and lights digit 0.
- Display latency from a bcd_valid strobe: at most 4·REFRESH_DIV cycles until digit 0 shows the value, and 3 further slots until the frame is complete.
- A strobe on the commit edge itself is displayed immediately, with latency 0 slots.
- Reset asserted mid-frame blanks all outputs at once. A pending value is lost.

## Configuration
- **SEVSEG_LZB_EN** (leading-zero blanking).
- Defined:
  - the hundreds digit is dark (an[2]=1, seg=1111111) when hold[11:8]=0;
  - the tens digit is dark when hold[11:4]=0;
  - the ones digit always lights, so value 0 shows "0".
- Undefined: all three digits always light, so 7 shows "007".
- Blanking is evaluated against the committed `hold`, never against `pend`.

## Structure
- **Shared package `sevenseg_pkg`:**
  - the ten digit patterns (SEG_0..SEG_9), SEG_DASH and SEG_OFF;
  - NUM_DIGITS = 4 and ACTIVE_DIGITS = 3.
- **Sub-module `bcd_seg_decode`:** purely combinational, 4-bit nibble in and 7-bit active-low pattern out, including the dash for nibbles > 9. It is instantiated once, on the muxed nibble.
- The counter, digit FSM, pending/commit logic and output registers stay in `sevenseg_scan`.

## Test plan
- **Reset:** assert reset mid-slot → an=1111, seg=1111111, dp=1 immediately, with no clock edge needed.
- **Basic scan:** REFRESH_DIV=4, strobe bcd=0x255 → after commit, slots show an/seg = 1110/0010010 (5), 1101/0010010 (5), 1011/0100100 (2), then 1111/1111111; the pattern repeats every 16 cycles.
- **No tearing:** strobe 0x123, then 0x456 during slot 1 of the same frame → the current frame stays 123 and the next frame shows 456 on all digits.
- **Commit-edge strobe:** strobe bcd_valid on the dig 3→0 tick with 0x089 → digit 0 shows 9 on that same edge, and pend_flag ends at 0.
- **Malformed BCD:** bcd=0x1A3 → the tens slot shows seg=0111111, while the other digits show 1 and 3.
- **Leading-zero blanking:** with SEVSEG_LZB_EN, bcd=0x007 → only an[0] ever goes low. Without the macro, all three slots light, showing 0, 0 and 7.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: active-low {g,f,e,d,c,b,a} digit patterns and display geometry shared by the scan driver
package sevenseg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int ACTIVE_DIGITS = 3;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
endpackage

// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: bcd/bcd_valid value input plus an/seg/dp active-low display lines; master = source, slave = driver
interface sevenseg_scan_if;
  import sevenseg_pkg::*;
  logic [11:0] bcd;
  logic bcd_valid;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0] seg;
  logic dp;
  modport master(output bcd, bcd_valid, input an, seg, dp);
  modport slave(input bcd, bcd_valid, output an, seg, dp);
endinterface

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational nibble (in nib[3:0]) to active-low segment pattern (out seg[6:0]), dash for nibbles above 9
module bcd_seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: 4-digit multiplexed 7-seg driver (clk, async reset, io: bcd/bcd_valid in, an/seg/dp out), frame-boundary commit, optional SEVSEG_LZB_EN leading-zero blanking
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic reset,
  sevenseg_scan_if.slave io
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic [1:0] dig, nd;
  logic [11:0] hold, pend, nhold;
  logic pend_flag, tick, commit, blank;
  logic [3:0] nib;
  logic [6:0] pat;
  assign tick = cnt == CW'(REFRESH_DIV - 1);
  assign nd = dig + 2'd1;
  assign commit = tick && dig == 2'd3;
  assign nhold = !commit ? hold : io.bcd_valid ? io.bcd : pend_flag ? pend : hold;
  assign nib = nd == 2'd0 ? nhold[3:0] : nd == 2'd1 ? nhold[7:4] : nhold[11:8];
`ifdef SEVSEG_LZB_EN
  assign blank = nd == 2'(ACTIVE_DIGITS) || (nd == 2'd2 && nhold[11:8] == 4'd0) || (nd == 2'd1 && nhold[11:4] == 8'd0);
`else
  assign blank = nd == 2'(ACTIVE_DIGITS);
`endif
  bcd_seg_decode u_dec (.nib(nib), .seg(pat));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dig <= 2'd3;
      hold <= '0;
      pend <= '0;
      pend_flag <= 1'b0;
      io.an <= '1;
      io.seg <= SEG_OFF;
      io.dp <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (io.bcd_valid) pend <= io.bcd;
      pend_flag <= !commit && (io.bcd_valid || pend_flag);
      hold <= nhold;
      io.dp <= 1'b1;
      if (tick) begin
        dig <= nd;
        io.an <= blank ? '1 : ~(4'b0001 << nd);
        io.seg <= blank ? SEG_OFF : pat;
      end
    end
  end
endmodule
